// File: rtl/instr_fetch_queue_if.sv
// Bus bundles for instr_fetch_queue: the instruction-memory read port (req/ack)
// and the instruction port to the datapath (valid/ready).

// Memory read handshake: req/addr are held from the cycle req rises until the
// cycle ack=1; ack may be given in the same cycle req rises, and rdata is only
// meaningful while ack=1. The instruction port moves one word on every cycle
// with valid=1 and ready=1.
interface ifq_imem_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [15:0]       rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

interface ifq_instr_if #(
    parameter int ADDR_W = 16
);
    logic              valid;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              ready;

    modport master (output valid, output instr, output pc, input ready);
    modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads instruction memory with one outstanding
// request and buffers words in a prefetch FIFO. Optional feature: IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    ifq_imem_if.master             imem,
    ifq_instr_if.master            fetch,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             state_dbg
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                LVL_W   = PTR_W + 1;
    localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0] discard_addr, discard_addr_nxt;
    logic [LVL_W-1:0]  count, count_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic [15:0]       word_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic              fifo_empty;
    logic              ack_ok;
    logic              word_ok;
    logic              bypass_take;
    logic              push;
    logic              pop;
    logic              credit_after;
    logic [ADDR_W-1:0] target_pc;

    assign fifo_empty = (count == '0);
    assign target_pc  = redirect_pc & ~ADDR_W'(1);
    assign level      = count;
    assign state_dbg  = state;

    // In IDLE the request is raised combinationally so a zero-wait memory can
    // answer in the same cycle; a same-cycle redirect suppresses it instead.
    always_comb begin
        imem.req = 1'b0;
        unique case (state)
            IDLE:          imem.req = reset && !redirect && (count < DEPTH_L);
            WAIT, DISCARD: imem.req = reset;
            default:       imem.req = 1'b0;
        endcase
    end

    assign imem.addr = (state == DISCARD) ? discard_addr : fetch_pc;

    assign ack_ok  = imem.ack && imem.req;
    assign word_ok = ack_ok && (state != DISCARD) && !redirect;

`ifdef IFQ_BYPASS_EN
    assign bypass_take = word_ok && fifo_empty && fetch.ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = word_ok && !bypass_take;
    assign pop  = !fifo_empty && fetch.ready && !redirect;

    always_comb begin
        count_nxt = count + LVL_W'(push) - LVL_W'(pop);
        if (redirect) begin
            count_nxt = '0;
        end
    end

    // Credit for a back-to-back request is judged on next cycle's occupancy.
    assign credit_after = (count_nxt < DEPTH_L);

    always_comb begin
        state_nxt        = state;
        fetch_pc_nxt     = fetch_pc;
        discard_addr_nxt = discard_addr;
        unique case (state)
            IDLE, WAIT: begin
                if (redirect) begin
                    fetch_pc_nxt = target_pc;
                    if (imem.req && !ack_ok) begin
                        discard_addr_nxt = fetch_pc;
                        state_nxt        = DISCARD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (ack_ok) begin
                    fetch_pc_nxt = fetch_pc + PC_STEP;
                    state_nxt    = credit_after ? WAIT : IDLE;
                end else if (imem.req) begin
                    state_nxt = WAIT;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_nxt = target_pc;
                end
                if (ack_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            discard_addr <= RESET_PC;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            discard_addr <= discard_addr_nxt;
            count        <= count_nxt;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(push);
                rd_ptr <= rd_ptr + PTR_W'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= imem.rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    always_comb begin
        fetch.valid = !fifo_empty;
        fetch.instr = '0;
        fetch.pc    = '0;
        if (!fifo_empty) begin
            fetch.instr = word_mem[rd_ptr];
            fetch.pc    = pc_mem[rd_ptr];
        end
        if (bypass_take) begin
            fetch.valid = 1'b1;
            fetch.instr = imem.rdata;
            fetch.pc    = fetch_pc;
        end
    end

endmodule
